btb_update_ctrl: RTL

Write-port controller for the branch target buffer (256 entries, 8-bit index, 4-bit tag, 1 valid flag, 2-bit direction counter, 32-bit target). It buffers branch-resolution updates arriving from the EX stage in a small FIFO and computes the saturating direction counter for each one. It also runs a full-table invalidate sweep on request, and owns the single BTB write port. The BTB read side in IF is unaffected.

---
 rtl/btb_update_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/btb_update_ctrl.sv
// BTB write-port controller: queues EX-stage branch updates, drains them one per cycle,
// and runs a full-table invalidate sweep. Define BTB_UPD_COALESCE_EN to merge same-index tail pushes.
module btb_update_ctrl #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 8,
    parameter int TAG_W = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       upd_valid_i,
    output logic                       upd_ready_o,
    input  logic [31:0]                upd_pc_i,
    input  logic [31:0]                upd_target_i,
    input  logic                       upd_taken_i,
    input  logic [1:0]                 upd_ctr_i,
    input  logic                       inv_req_i,
    output logic                       inv_busy_o,
    output logic                       btb_we_o,
    output logic [IDX_W-1:0]           btb_idx_o,
    output logic [TAG_W-1:0]           btb_tag_o,
    output logic                       btb_valid_o,
    output logic [1:0]                 btb_ctr_o,
    output logic [31:0]                btb_target_o,
    output logic [$clog2(DEPTH+1)-1:0] pending_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic [1:0]       ctr;
    } upd_entry_t;

    typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

    state_t            state_q, state_d;
    upd_entry_t        fifo_q [DEPTH];
    upd_entry_t        fifo_d [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]  sweep_q, sweep_d;
    logic              we_q, we_d;
    logic              valid_q, valid_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [1:0]        ctr_q, ctr_d;
    logic [31:0]       target_q, target_d;

    upd_entry_t        push_entry;
    logic [PW-1:0]     tail_ptr;
    logic              full, empty, push, pop, coalesce;
    logic              unused_pc;

    function automatic logic [1:0] next_ctr(input logic [1:0] ctr, input logic taken);
        logic [1:0] r;
        r = ctr;
        if (taken && ctr != 2'd3)
            r = ctr + 2'd1;
        else if (!taken && ctr != 2'd0)
            r = ctr - 2'd1;
        return r;
    endfunction

    assign unused_pc = ^{upd_pc_i[31:IDX_W+TAG_W+2], upd_pc_i[1:0]};

    assign push_entry.idx    = upd_pc_i[IDX_W+1:2];
    assign push_entry.tag    = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];
    assign push_entry.target = upd_target_i;
    assign push_entry.ctr    = next_ctr(upd_ctr_i, upd_taken_i);

    assign full        = (cnt_q == CW'(DEPTH));
    assign empty       = (cnt_q == '0);
    assign upd_ready_o = (state_q == ST_IDLE) && !full && !inv_req_i;
    assign push        = upd_valid_i && upd_ready_o;
    // An invalidate request in IDLE suppresses the drain: the queue is stale.
    assign pop         = (state_q == ST_IDLE) && !inv_req_i && !empty;
    assign tail_ptr    = wr_ptr_q - PW'(1);

`ifdef BTB_UPD_COALESCE_EN
    // The tail may only be rewritten when it is not leaving the queue this cycle.
    assign coalesce = push && !empty && (fifo_q[tail_ptr].idx == push_entry.idx)
                      && !((cnt_q == CW'(1)) && pop);
`else
    assign coalesce = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        sweep_d  = sweep_q;
        we_d     = 1'b0;
        valid_d  = valid_q;
        idx_d    = idx_q;
        tag_d    = tag_q;
        ctr_d    = ctr_q;
        target_d = target_q;
        case (state_q)
            ST_IDLE: begin
                if (inv_req_i) begin
                    state_d  = ST_SWEEP;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    cnt_d    = '0;
                    sweep_d  = '0;
                    we_d     = 1'b1;
                    valid_d  = 1'b0;
                    idx_d    = '0;
                    tag_d    = '0;
                    ctr_d    = '0;
                    target_d = '0;
                end else begin
                    if (pop) begin
                        we_d     = 1'b1;
                        valid_d  = 1'b1;
                        idx_d    = fifo_q[rd_ptr_q].idx;
                        tag_d    = fifo_q[rd_ptr_q].tag;
                        ctr_d    = fifo_q[rd_ptr_q].ctr;
                        target_d = fifo_q[rd_ptr_q].target;
                        rd_ptr_d = rd_ptr_q + PW'(1);
                    end
                    if (push) begin
                        if (coalesce) begin
                            fifo_d[tail_ptr] = push_entry;
                        end else begin
                            fifo_d[wr_ptr_q] = push_entry;
                            wr_ptr_d         = wr_ptr_q + PW'(1);
                        end
                    end
                    cnt_d = cnt_q + CW'(push && !coalesce) - CW'(pop);
                end
            end
            ST_SWEEP: begin
                if (sweep_q == '1) begin
                    state_d = ST_IDLE;
                end else begin
                    sweep_d  = sweep_q + IDX_W'(1);
                    we_d     = 1'b1;
                    valid_d  = 1'b0;
                    idx_d    = sweep_q + IDX_W'(1);
                    tag_d    = '0;
                    ctr_d    = '0;
                    target_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            sweep_q  <= '0;
            we_q     <= 1'b0;
            valid_q  <= 1'b0;
            idx_q    <= '0;
            tag_q    <= '0;
            ctr_q    <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            sweep_q  <= sweep_d;
            we_q     <= we_d;
            valid_q  <= valid_d;
            idx_q    <= idx_d;
            tag_q    <= tag_d;
            ctr_q    <= ctr_d;
            target_q <= target_d;
        end
    end

    // Queue storage is qualified by the pointers, so it needs no reset.
    always_ff @(posedge clk_i) begin
        fifo_q <= fifo_d;
    end

    assign inv_busy_o   = (state_q == ST_SWEEP);
    assign btb_we_o     = we_q;
    assign btb_idx_o    = idx_q;
    assign btb_tag_o    = tag_q;
    assign btb_valid_o  = valid_q;
    assign btb_ctr_o    = ctr_q;
    assign btb_target_o = target_q;
    assign pending_o    = cnt_q;
endmodule
